// File: rtl/axil_mini_responder.sv
// AXI-lite-style register-file responder: 2**ADDR_W registers of DATA_W bits,
// independent write (AW/W/B) and read (AR/R) paths, one write outstanding at a time.
module axil_mini_responder #(
  parameter int                ADDR_W    = 3,
  parameter int                DATA_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aw_valid,
  output logic              aw_ready,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [DATA_W-1:0] w_data,
  output logic              b_valid,
  input  logic              b_ready,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [DATA_W-1:0] r_data,
  output logic [3:0]        wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Handshake rule for every channel: a transfer happens at a rising edge where
  // valid and ready are both high; valid, once raised, holds until that edge.

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_full;
  logic [ADDR_W-1:0] aw_q;
  logic              w_full;
  logic [DATA_W-1:0] w_q;

  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              ar_hs;
  logic              r_hs;
  logic              commit;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;

  assign aw_ready = !aw_full && !b_valid;
  assign w_ready  = !w_full && !b_valid;
  assign ar_ready = !r_valid;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;
  assign b_hs  = b_valid && b_ready;
  assign ar_hs = ar_valid && ar_ready;
  assign r_hs  = r_valid && r_ready;

  // A held half and a live half may combine, so take each from wherever it is.
  assign commit      = (aw_full || aw_hs) && (w_full || w_hs) && !b_valid;
  assign commit_addr = aw_full ? aw_q : aw_addr;
  assign commit_data = w_full ? w_q : w_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RESET_VAL;
      end
    end else if (commit) begin
      mem[commit_addr] <= commit_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_full  <= 1'b0;
      aw_q     <= '0;
      w_full   <= 1'b0;
      w_q      <= '0;
      b_valid  <= 1'b0;
      wr_count <= 4'd0;
    end else begin
      if (aw_hs) begin
        aw_q <= aw_addr;
      end
      if (w_hs) begin
        w_q <= w_data;
      end
      if (commit) begin
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
        b_valid  <= 1'b1;
        wr_count <= wr_count + 4'd1;
      end else begin
        if (aw_hs) begin
          aw_full <= 1'b1;
        end
        if (w_hs) begin
          w_full <= 1'b1;
        end
        if (b_hs) begin
          b_valid <= 1'b0;
        end
      end
    end
  end

  // The read samples mem before any same-edge commit lands: no write-to-read bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_valid <= 1'b1;
      r_data  <= mem[ar_addr];
    end else if (r_hs) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axil_mini_responder.sv
// Directed bench for axil_mini_responder: table-driven write/read vectors plus
// hand-written sequences for ordering, backpressure, collision and reset cases.
module tb_axil_mini_responder;

  logic       clk;
  logic       rst;
  logic       aw_valid;
  logic       aw_ready;
  logic [2:0] aw_addr;
  logic       w_valid;
  logic       w_ready;
  logic [3:0] w_data;
  logic       b_valid;
  logic       b_ready;
  logic       ar_valid;
  logic       ar_ready;
  logic [2:0] ar_addr;
  logic       r_valid;
  logic       r_ready;
  logic [3:0] r_data;
  logic [3:0] wr_count;

  int n_checks;
  int n_fail;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
    logic [3:0] exp_cnt;
  } wr_vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] exp_data;
  } rd_vec_t;

  wr_vec_t wr_tab[17];
  rd_vec_t rd_tab[8];

  axil_mini_responder dut (
    .clk      (clk),
    .rst      (rst),
    .aw_valid (aw_valid),
    .aw_ready (aw_ready),
    .aw_addr  (aw_addr),
    .w_valid  (w_valid),
    .w_ready  (w_ready),
    .w_data   (w_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .ar_valid (ar_valid),
    .ar_ready (ar_ready),
    .ar_addr  (ar_addr),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .wr_count (wr_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    aw_valid = 1'b0;
    aw_addr  = '0;
    w_valid  = 1'b0;
    w_data   = '0;
    b_ready  = 1'b0;
    ar_valid = 1'b0;
    ar_addr  = '0;
    r_ready  = 1'b0;
  endtask

  // driver: same-cycle AW+W from idle, B accepted the following cycle
  task automatic do_write(input logic [2:0] a, input logic [3:0] d, input logic [3:0] exp_cnt);
    aw_valid = 1'b1;
    aw_addr  = a;
    w_valid  = 1'b1;
    w_data   = d;
    b_ready  = 1'b1;
    check("wr_aw_ready", aw_ready, 1'b1);
    check("wr_w_ready", w_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    check("wr_b_valid", b_valid, 1'b1);
    check("wr_count", wr_count, exp_cnt);
    tick();
    check("wr_b_drop", b_valid, 1'b0);
    b_ready = 1'b0;
  endtask

  // driver + scoreboard: expectation queued, popped when R arrives
  task automatic do_read(input logic [2:0] a, input logic [3:0] exp_d);
    logic [3:0] e;
    exp_q.push_back(exp_d);
    ar_valid = 1'b1;
    ar_addr  = a;
    check("rd_ar_ready", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    check("rd_r_valid", r_valid, 1'b1);
    e = exp_q.pop_front();
    check("rd_r_data", r_data, e);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("rd_r_drop", r_valid, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    wr_tab[0]  = '{3'd0, 4'h1, 4'd1};
    wr_tab[1]  = '{3'd1, 4'h2, 4'd2};
    wr_tab[2]  = '{3'd2, 4'h3, 4'd3};
    wr_tab[3]  = '{3'd3, 4'h4, 4'd4};
    wr_tab[4]  = '{3'd4, 4'h5, 4'd5};
    wr_tab[5]  = '{3'd5, 4'h6, 4'd6};
    wr_tab[6]  = '{3'd6, 4'h7, 4'd7};
    wr_tab[7]  = '{3'd7, 4'h8, 4'd8};
    wr_tab[8]  = '{3'd0, 4'h9, 4'd9};
    wr_tab[9]  = '{3'd1, 4'hA, 4'd10};
    wr_tab[10] = '{3'd2, 4'hB, 4'd11};
    wr_tab[11] = '{3'd3, 4'hC, 4'd12};
    wr_tab[12] = '{3'd4, 4'hD, 4'd13};
    wr_tab[13] = '{3'd5, 4'hE, 4'd14};
    wr_tab[14] = '{3'd6, 4'hF, 4'd15};
    wr_tab[15] = '{3'd7, 4'h0, 4'd0};
    wr_tab[16] = '{3'd0, 4'h3, 4'd1};

    rd_tab[0] = '{3'd0, 4'h3};
    rd_tab[1] = '{3'd1, 4'hA};
    rd_tab[2] = '{3'd2, 4'hB};
    rd_tab[3] = '{3'd3, 4'hC};
    rd_tab[4] = '{3'd4, 4'hD};
    rd_tab[5] = '{3'd5, 4'hE};
    rd_tab[6] = '{3'd6, 4'hF};
    rd_tab[7] = '{3'd7, 4'h0};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();

    // reset state, sampled while rst is still high
    check("rst_aw_ready", aw_ready, 1'b1);
    check("rst_w_ready", w_ready, 1'b1);
    check("rst_ar_ready", ar_ready, 1'b1);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_r_data", r_data, 4'h0);
    check("rst_wr_count", wr_count, 4'd0);
    rst = 1'b0;
    tick();

    // same-cycle AW+W, then read back
    do_write(3'd3, 4'hA, 4'd1);
    check("t1_b_once", b_valid, 1'b0);
    do_read(3'd3, 4'hA);

    // W two cycles ahead of AW
    w_valid = 1'b1;
    w_data  = 4'h5;
    b_ready = 1'b1;
    tick();
    w_valid = 1'b0;
    check("t2_w_ready_low", w_ready, 1'b0);
    check("t2_aw_ready_hi", aw_ready, 1'b1);
    tick();
    check("t2_w_ready_still_low", w_ready, 1'b0);
    check("t2_no_b_yet", b_valid, 1'b0);
    aw_valid = 1'b1;
    aw_addr  = 3'd6;
    tick();
    aw_valid = 1'b0;
    check("t2_b_valid", b_valid, 1'b1);
    check("t2_wr_count", wr_count, 4'd2);
    tick();
    check("t2_b_drop", b_valid, 1'b0);
    b_ready = 1'b0;
    do_read(3'd6, 4'h5);
    do_read(3'd0, 4'h0);

    // B backpressure for 5 cycles with a new AW waiting
    aw_valid = 1'b1;
    aw_addr  = 3'd1;
    w_valid  = 1'b1;
    w_data   = 4'h7;
    tick();
    w_valid = 1'b0;
    aw_addr = 3'd4;
    for (int i = 0; i < 5; i++) begin
      check("t3_b_hold", b_valid, 1'b1);
      check("t3_aw_ready_low", aw_ready, 1'b0);
      check("t3_w_ready_low", w_ready, 1'b0);
      tick();
    end
    b_ready = 1'b1;
    check("t3_aw_ready_at_b_ready", aw_ready, 1'b0);
    check("t3_count_held", wr_count, 4'd3);
    tick();
    check("t3_b_done", b_valid, 1'b0);
    check("t3_aw_ready_back", aw_ready, 1'b1);
    tick();
    aw_valid = 1'b0;
    check("t3_aw_full", aw_ready, 1'b0);
    check("t3_no_commit_yet", b_valid, 1'b0);
    w_valid = 1'b1;
    w_data  = 4'h3;
    check("t3_w_ready", w_ready, 1'b1);
    tick();
    w_valid = 1'b0;
    check("t3_b_valid2", b_valid, 1'b1);
    check("t3_wr_count2", wr_count, 4'd4);
    tick();
    b_ready = 1'b0;
    do_read(3'd1, 4'h7);
    do_read(3'd4, 4'h3);

    // same-cycle commit and read of one register: old value returned
    do_write(3'd2, 4'h1, 4'd5);
    aw_valid = 1'b1;
    aw_addr  = 3'd2;
    w_valid  = 1'b1;
    w_data   = 4'h9;
    ar_valid = 1'b1;
    ar_addr  = 3'd2;
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    ar_valid = 1'b0;
    check("t4_r_valid", r_valid, 1'b1);
    check("t4_r_data_old", r_data, 4'h1);
    check("t4_b_valid", b_valid, 1'b1);
    check("t4_wr_count", wr_count, 4'd6);
    b_ready = 1'b1;
    r_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    r_ready = 1'b0;
    do_read(3'd2, 4'h9);

    // R backpressure for 3 cycles with a second AR waiting
    do_write(3'd5, 4'hB, 4'd7);
    ar_valid = 1'b1;
    ar_addr  = 3'd5;
    tick();
    ar_addr = 3'd3;
    for (int i = 0; i < 3; i++) begin
      check("t5_r_hold", r_valid, 1'b1);
      check("t5_r_data_hold", r_data, 4'hB);
      check("t5_ar_ready_low", ar_ready, 1'b0);
      tick();
    end
    r_ready = 1'b1;
    check("t5_ar_ready_at_r_ready", ar_ready, 1'b0);
    tick();
    r_ready = 1'b0;
    check("t5_r_done", r_valid, 1'b0);
    check("t5_r_data_kept", r_data, 4'hB);
    check("t5_ar_ready_back", ar_ready, 1'b1);
    tick();
    ar_valid = 1'b0;
    check("t5_r_valid2", r_valid, 1'b1);
    check("t5_r_data2", r_data, 4'hA);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;

    // counter wrap: 17 writes from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      do_write(wr_tab[i].addr, wr_tab[i].data, wr_tab[i].exp_cnt);
    end
    check("wrap_count", wr_count, 4'd1);
    for (int i = 0; i < 8; i++) begin
      do_read(rd_tab[i].addr, rd_tab[i].exp_data);
    end

    // reset while a W is held (and a read response pending)
    w_valid  = 1'b1;
    w_data   = 4'h7;
    ar_valid = 1'b1;
    ar_addr  = 3'd1;
    tick();
    check("t6_w_held", w_ready, 1'b0);
    check("t6_r_pending", r_valid, 1'b1);
    ar_valid = 1'b0;
    aw_valid = 1'b1;
    aw_addr  = 3'd1;
    rst = 1'b1;
    tick();
    aw_valid = 1'b0;
    w_valid  = 1'b0;
    rst = 1'b0;
    check("t6_b_valid", b_valid, 1'b0);
    check("t6_r_valid", r_valid, 1'b0);
    check("t6_r_data", r_data, 4'h0);
    check("t6_wr_count", wr_count, 4'd0);
    check("t6_aw_ready", aw_ready, 1'b1);
    check("t6_w_ready", w_ready, 1'b1);
    check("t6_ar_ready", ar_ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      do_read(rd_tab[i].addr, 4'h0);
    end
    // a lone AW must not pair with the W dropped by reset
    aw_valid = 1'b1;
    aw_addr  = 3'd2;
    b_ready  = 1'b1;
    tick();
    aw_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6_no_b", b_valid, 1'b0);
      check("t6_count_zero", wr_count, 4'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_mini_responder.md
# axil_mini_responder

Register-file responder for the team's 3-bit-address / 4-bit-data AXI-lite-style bus: it accepts write address, write data and read address from the bus initiator, and returns write responses and read data. It holds 8 × 4-bit registers. It sits at the far end of the bus from the master and is the drop-in memory-mapped target for the seven-segment demo top.

## Interface
Parameters:
- ADDR_W, 3, address width; register count is 2**ADDR_W.
- DATA_W, 4, data width.
- RESET_VAL, 4'h0, value loaded into every register on reset.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- aw_valid  input  1  write address valid.
- aw_ready  output  1  write address ready.
- aw_addr  input  ADDR_W  write address.
- w_valid  input  1  write data valid.
- w_ready  output  1  write data ready.
- w_data  input  DATA_W  write data.
- b_valid  output  1  write response valid.
- b_ready  input  1  write response ready.
- ar_valid  input  1  read address valid.
- ar_ready  output  1  read address ready.
- ar_addr  input  ADDR_W  read address.
- r_valid  output  1  read data valid.
- r_ready  input  1  read data ready.
- r_data  output  DATA_W  read data.
- wr_count  output  4  number of committed writes, modulo 16.

## Operation
- A handshake occurs on a channel when valid and ready are both high at a rising edge.
- Write path state consists of aw_full, aw_q, w_full, w_q, and b_valid.
  - aw_ready = !aw_full && !b_valid.
  - w_ready = !w_full && !b_valid.
  - The two readies are combinational.
- AW and W may arrive in either order or in the same cycle.
  - An AW handshake sets aw_full and latches aw_addr into aw_q.
  - A W handshake sets w_full and latches w_data into w_q.
- Commit condition: address available (aw_full, or an AW handshake this cycle) AND data available (w_full, or a W handshake this cycle) AND !b_valid.
- At the commit edge:
  - mem[addr] <= data, using the held value or the live bus value as applicable.
  - aw_full <= 0 and w_full <= 0.
  - b_valid <= 1.
  - wr_count <= wr_count + 1, wrapping 15 to 0.
- While b_valid = 1, both aw_ready and w_ready are low.
- A B handshake clears b_valid.
- Read path state consists of r_valid and r_data.
  - ar_ready = !r_valid.
  - An AR handshake loads r_data <= mem[ar_addr] and sets r_valid <= 1.
  - r_data stays stable while r_valid = 1.
  - An R handshake clears r_valid. r_data keeps its last value.
- The read and write paths are fully independent and may both be active in the same cycle.
- Same-cycle write commit and AR handshake to the same address: r_data receives the OLD register value. There is no bypass.
- Write collision rules:
  - Only one write is outstanding at a time.
  - A second AW while aw_full = 1 is not accepted; aw_ready stays low until the pending write commits and its B handshake completes.
  - The same applies to W.

## Timing
- Reset (rst high at an edge) sets:
  - every mem entry = RESET_VAL,
  - aw_full = w_full = 0,
  - b_valid = 0, r_valid = 0,
  - r_data = 0, wr_count = 0.
- Readies follow their equations, so aw_ready, w_ready and ar_ready read 1 during and after reset.
- Handshakes in a cycle where rst is high are discarded.
- Reset mid-transaction drops any held AW/W, pending B, and pending R. No response is issued afterwards.
- Write latency: b_valid rises in the cycle after the later of the AW and W handshakes. With both in cycle T, b_valid = 1 in cycle T+1.
- Best-case write throughput: one write per 2 cycles (accept, then respond), provided b_ready is held high.
- Read latency: r_valid = 1 in the cycle after the AR handshake. Best-case throughput is one read per 2 cycles.
- b_valid and r_valid are never deasserted without their matching handshake, except by reset.
- wr_count updates on the commit edge, in the same cycle b_valid rises.

## Test plan
- Reset, then AW addr 3 and W data 4'hA in the same cycle, b_ready = 1. Required: b_valid high the next cycle for exactly one cycle; wr_count = 1. Then AR addr 3: r_valid the next cycle with r_data = 4'hA.
- W data 4'h5 two cycles before AW addr 6. Required: w_ready low after the W handshake; commit on the AW cycle; b_valid the next cycle. A subsequent read of addr 6 returns 4'h5. A read of untouched addr 0 returns RESET_VAL.
- b_ready held low for 5 cycles after a commit. Required: b_valid stays high; aw_ready and w_ready stay low; a new AW is not accepted until one cycle after b_ready rises.
- Register 2 holds 4'h1. In one cycle, a write commit of 4'h9 to addr 2 and an AR to addr 2. Required: r_data = 4'h1. A following read returns 4'h9.
- r_ready held low for 3 cycles. Required: r_valid and r_data held stable and ar_ready low. An AR presented meanwhile is accepted only in the cycle after the R handshake.
- 17 back-to-back writes, then rst asserted while a W is held. Required: wr_count wraps to 1 after the 17 writes. After reset, all outputs are at their reset values, all registers read RESET_VAL, and no b_valid appears.
